// File: rtl/code_lock_checker_pkg.sv
// Shared types and constants for the code lock checker.
package code_lock_pkg;

    localparam int unsigned NIBBLE_W     = 4;
    localparam int unsigned DIGITS       = 4;
    localparam int unsigned CODE_W       = NIBBLE_W * DIGITS;
    localparam int unsigned CNT_W        = 3;
    localparam logic [NIBBLE_W-1:0] BLANK_NIBBLE = 4'hF;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCollect = 3'd1,
        StCompare = 3'd2,
        StPass    = 3'd3,
        StFail    = 3'd4,
        StRearm   = 3'd5,
        StLockout = 3'd6
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/code_lock_checker_if.sv
// Encoder-facing code bus plus lock status outputs.
interface code_lock_checker_if;
    import code_lock_pkg::*;

    logic [CODE_W-1:0]   Code;
    logic [CNT_W-1:0]    Code_Bit;
    logic                Clear;
    logic                Unlock;
    logic                Alarm;
    logic [NIBBLE_W-1:0] Fail_Cnt;
    logic                Locked;
    logic [2:0]          State_Out;

    modport master (
        output Code, Code_Bit, Clear,
        input  Unlock, Alarm, Fail_Cnt, Locked, State_Out
    );

    modport slave (
        input  Code, Code_Bit, Clear,
        output Unlock, Alarm, Fail_Cnt, Locked, State_Out
    );

endinterface

// File: rtl/code_lock_checker_timer.sv
// Loadable down counter that stops at zero; shared by the hold and lockout periods.
module code_lock_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/code_lock_checker.sv
// Compares the encoder's 4-digit code with PASSWORD and pulses Unlock/Alarm.
// Optional lockout after MAX_FAIL consecutive failures: define CODE_LOCK_LOCKOUT_EN.
module code_lock_checker
    import code_lock_pkg::*;
#(
    parameter logic [15:0] PASSWORD       = 16'h4321,
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
    input  logic CLK,
    input  logic RESET_N,
    code_lock_checker_if.slave bus
);

    localparam int unsigned TIMER_W = $clog2(max_u(HOLD_CYCLES, LOCKOUT_CYCLES)) + 1;
    localparam logic [TIMER_W-1:0]  HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [NIBBLE_W-1:0] FAIL_MAX  = NIBBLE_W'(MAX_FAIL);

    logic [CODE_W-1:0]   r_code;
    logic [CNT_W-1:0]    r_code_bit;
    state_e              r_state;
    logic                r_unlock;
    logic                r_alarm;
    logic [NIBBLE_W-1:0] r_fail_cnt;

    logic                w_complete;
    logic                w_tmr_load;
    logic [TIMER_W-1:0]  w_tmr_val;
    logic                w_tmr_zero;

    // Digit counts 5..7 count as complete; only the code value is compared.
    assign w_complete = (r_code_bit >= CNT_W'(4));

`ifdef CODE_LOCK_LOCKOUT_EN
    localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    logic r_locked;
    logic w_lock_now;
    assign w_lock_now = (r_fail_cnt == FAIL_MAX);
    assign bus.Locked = r_locked;
`else
    assign bus.Locked = 1'b0;
`endif

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = HOLD_LOAD;
        if (!bus.Clear && r_state == StCompare) begin
            w_tmr_load = 1'b1;
        end
`ifdef CODE_LOCK_LOCKOUT_EN
        if (!bus.Clear && r_state == StFail && w_tmr_zero && w_lock_now) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = LOCK_LOAD;
        end
`endif
    end

    code_lock_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_code     <= {DIGITS{BLANK_NIBBLE}};
            r_code_bit <= '0;
            r_state    <= StIdle;
            r_unlock   <= 1'b0;
            r_alarm    <= 1'b0;
            r_fail_cnt <= '0;
`ifdef CODE_LOCK_LOCKOUT_EN
            r_locked   <= 1'b0;
`endif
        end else begin
            r_code     <= bus.Code;
            r_code_bit <= bus.Code_Bit;
            // A FAIL increment is committed on entry, so aborting leaves it in place.
            if (bus.Clear && r_state != StLockout) begin
                r_state  <= StRearm;
                r_unlock <= 1'b0;
                r_alarm  <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (r_code_bit != '0) r_state <= StCollect;
                    end
                    StCollect: begin
                        if (w_complete) r_state <= StCompare;
                        else if (r_code_bit == '0) r_state <= StIdle;
                    end
                    StCompare: begin
                        if (r_code == PASSWORD) begin
                            r_state    <= StPass;
                            r_unlock   <= 1'b1;
                            r_fail_cnt <= '0;
                        end else begin
                            r_state <= StFail;
                            r_alarm <= 1'b1;
                            if (r_fail_cnt < FAIL_MAX) r_fail_cnt <= r_fail_cnt + 4'd1;
                        end
                    end
                    StPass: begin
                        if (w_tmr_zero) begin
                            r_unlock <= 1'b0;
                            r_state  <= StRearm;
                        end
                    end
                    StFail: begin
                        if (w_tmr_zero) begin
                            r_alarm <= 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
                            if (w_lock_now) begin
                                r_state  <= StLockout;
                                r_locked <= 1'b1;
                            end else begin
                                r_state <= StRearm;
                            end
`else
                            r_state <= StRearm;
`endif
                        end
                    end
                    // Wait for the encoder to clear so a held code cannot re-trigger.
                    StRearm: begin
                        if (r_code_bit == '0) r_state <= StIdle;
                    end
`ifdef CODE_LOCK_LOCKOUT_EN
                    StLockout: begin
                        if (w_tmr_zero) begin
                            r_locked   <= 1'b0;
                            r_fail_cnt <= '0;
                            r_state    <= StRearm;
                        end
                    end
`endif
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign bus.Unlock    = r_unlock;
    assign bus.Alarm     = r_alarm;
    assign bus.Fail_Cnt  = r_fail_cnt;
    assign bus.State_Out = r_state;

endmodule

// File: tb/tb_code_lock_checker.sv
// Directed self-checking bench for code_lock_checker (HOLD=8, LOCKOUT=16, MAX_FAIL=3).
module tb_code_lock_checker;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    code_lock_checker_if bus ();

    code_lock_checker #(
        .PASSWORD       (16'h4321),
        .HOLD_CYCLES    (8),
        .MAX_FAIL       (3),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One digit, then the final count; returns at the edge where PASS/FAIL is entered.
    task automatic attempt(input string tag, input logic [15:0] code, input logic [2:0] bits,
                           input bit clr);
        bus.Code     = code;
        bus.Code_Bit = 3'd1;
        step(1);
        bus.Code_Bit = bits;
        step(2);
        chk({tag, "_compare"}, {29'd0, bus.State_Out}, 32'd2);
        chk({tag, "_pre"}, {30'd0, bus.Unlock, bus.Alarm}, 32'd0);
        if (clr) bus.Clear = 1'b1;
        step(1);
        bus.Clear = 1'b0;
    endtask

    task automatic measure(input string tag, input bit want_unlock, input int exp_len);
        int cnt;
        bit other;
        cnt   = 0;
        other = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((want_unlock ? bus.Unlock : bus.Alarm) !== 1'b1) break;
            cnt++;
            if ((want_unlock ? bus.Alarm : bus.Unlock) !== 1'b0) other = 1'b1;
            step(1);
        end
        chk({tag, "_len"}, cnt, exp_len);
        chk({tag, "_excl"}, {31'd0, other}, 32'd0);
    endtask

    task automatic rearm(input string tag);
        bus.Code_Bit = 3'd0;
        bus.Code     = 16'hFFFF;
        step(2);
        chk({tag, "_idle"}, {29'd0, bus.State_Out}, 32'd0);
    endtask

    initial begin
        int  cnt;
        bit  seen;
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus.Code     = 16'hFFFF;
        bus.Code_Bit = 3'd0;
        bus.Clear    = 1'b0;
        #2;
        chk("rst_unlock", {31'd0, bus.Unlock}, 32'd0);
        chk("rst_alarm", {31'd0, bus.Alarm}, 32'd0);
        chk("rst_failcnt", {28'd0, bus.Fail_Cnt}, 32'd0);
        chk("rst_locked", {31'd0, bus.Locked}, 32'd0);
        chk("rst_state", {29'd0, bus.State_Out}, 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Correct code, then hold the count at 4 with no second pulse
        attempt("t1", 16'h4321, 3'd4, 1'b0);
        chk("t1_failcnt", {28'd0, bus.Fail_Cnt}, 32'd0);
        measure("t1_unlock", 1'b1, 8);
        chk("t1_rearm", {29'd0, bus.State_Out}, 32'd5);
        step(5);
        chk("t1_hold_nopulse", {30'd0, bus.Unlock, bus.Alarm}, 32'd0);
        chk("t1_hold_rearm", {29'd0, bus.State_Out}, 32'd5);
        rearm("t1");

        // Wrong code
        attempt("t2", 16'h4322, 3'd4, 1'b0);
        chk("t2_failcnt", {28'd0, bus.Fail_Cnt}, 32'd1);
        measure("t2_alarm", 1'b0, 8);
        chk("t2_rearm", {29'd0, bus.State_Out}, 32'd5);
        rearm("t2");

        // Partial entry abandoned by the encoder
        bus.Code     = 16'hFFF4;
        bus.Code_Bit = 3'd1;
        step(1);
        bus.Code     = 16'hFF34;
        bus.Code_Bit = 3'd2;
        step(1);
        chk("t4_collect", {29'd0, bus.State_Out}, 32'd1);
        bus.Code     = 16'hFFFF;
        bus.Code_Bit = 3'd0;
        step(2);
        chk("t4_idle", {29'd0, bus.State_Out}, 32'd0);
        chk("t4_failcnt", {28'd0, bus.Fail_Cnt}, 32'd1);
        chk("t4_nopulse", {30'd0, bus.Unlock, bus.Alarm}, 32'd0);

        // Two more consecutive failures reach MAX_FAIL
        attempt("t3a", 16'h1234, 3'd4, 1'b0);
        chk("t3a_failcnt", {28'd0, bus.Fail_Cnt}, 32'd2);
        measure("t3a_alarm", 1'b0, 8);
        rearm("t3a");
        attempt("t3b", 16'h9999, 3'd4, 1'b0);
        chk("t3b_failcnt", {28'd0, bus.Fail_Cnt}, 32'd3);
        measure("t3b_alarm", 1'b0, 8);
`ifdef CODE_LOCK_LOCKOUT_EN
        chk("t3_locked", {31'd0, bus.Locked}, 32'd1);
        chk("t3_lock_state", {29'd0, bus.State_Out}, 32'd6);
        bus.Code     = 16'h4321;
        bus.Code_Bit = 3'd4;
        bus.Clear    = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Locked !== 1'b1) break;
            cnt++;
            if (bus.Unlock !== 1'b0) seen = 1'b1;
            step(1);
        end
        bus.Clear = 1'b0;
        chk("t3_lock_len", cnt, 32'd16);
        chk("t3_lock_ignored", {31'd0, seen}, 32'd0);
        chk("t3_post_failcnt", {28'd0, bus.Fail_Cnt}, 32'd0);
        chk("t3_post_rearm", {29'd0, bus.State_Out}, 32'd5);
        step(3);
        chk("t3_post_nounlock", {31'd0, bus.Unlock}, 32'd0);
        rearm("t3");
`else
        chk("t3_nolock", {31'd0, bus.Locked}, 32'd0);
        chk("t3_rearm", {29'd0, bus.State_Out}, 32'd5);
        rearm("t3b");
        attempt("t3c", 16'h5555, 3'd4, 1'b0);
        chk("t3c_saturate", {28'd0, bus.Fail_Cnt}, 32'd3);
        measure("t3c_alarm", 1'b0, 8);
        rearm("t3c");
`endif
        attempt("t3d", 16'h4321, 3'd4, 1'b0);
        chk("t3d_failcnt", {28'd0, bus.Fail_Cnt}, 32'd0);
        measure("t3d_unlock", 1'b1, 8);
        rearm("t3d");

        // Clear in the COMPARE cycle wins
        attempt("t5a", 16'h4321, 3'd4, 1'b1);
        chk("t5a_state", {29'd0, bus.State_Out}, 32'd5);
        chk("t5a_nopulse", {30'd0, bus.Unlock, bus.Alarm}, 32'd0);
        chk("t5a_failcnt", {28'd0, bus.Fail_Cnt}, 32'd0);
        step(3);
        chk("t5a_still_none", {30'd0, bus.Unlock, bus.Alarm}, 32'd0);
        rearm("t5a");

        // Clear mid-PASS
        attempt("t5b", 16'h4321, 3'd4, 1'b0);
        chk("t5b_unlock", {31'd0, bus.Unlock}, 32'd1);
        step(3);
        chk("t5b_unlock_mid", {31'd0, bus.Unlock}, 32'd1);
        bus.Clear = 1'b1;
        step(1);
        bus.Clear = 1'b0;
        chk("t5b_dropped", {31'd0, bus.Unlock}, 32'd0);
        chk("t5b_state", {29'd0, bus.State_Out}, 32'd5);
        rearm("t5b");

        // Async reset mid-PASS, then a 5-digit count counts as complete
        attempt("t6", 16'h4321, 3'd4, 1'b0);
        step(2);
        chk("t6_unlock_pre", {31'd0, bus.Unlock}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_unlock", {31'd0, bus.Unlock}, 32'd0);
        chk("t6_async_state", {29'd0, bus.State_Out}, 32'd0);
        bus.Code     = 16'hFFFF;
        bus.Code_Bit = 3'd0;
        step(2);
        rst_n = 1'b1;
        step(1);
        attempt("t6b", 16'h4321, 3'd5, 1'b0);
        measure("t6b_unlock", 1'b1, 8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
